biriscv_fetch_frontend: RTL and testbench



---
 rtl/biriscv_fetch_frontend_pkg.sv | 28 ++
 rtl/biriscv_fetch_skid.sv | 47 ++++
 rtl/biriscv_fetch_frontend.sv | 156 +++++++++++++++
 tb/tb_biriscv_fetch_frontend.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_fetch_frontend_pkg.sv
// Shared definitions for the dual-issue fetch front end: privilege encoding,
// filler instruction and the layout of one fetch entry handed to decode.
package biriscv_defs;

  localparam logic [1:0]  PRIV_MACHINE = 2'b11;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;

  localparam int INSTR_W = 64;
  localparam int PC_W    = 32;
  localparam int PRED_W  = 2;
  localparam int FAULT_W = 2;
  localparam int ENTRY_W = INSTR_W + PC_W + PRED_W + FAULT_W;

  // One instruction pair as seen by decode (100 bits).
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PRED_W-1:0]  pred;
    logic               fault_fetch;
    logic               fault_page;
  } fetch_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/biriscv_fetch_skid.sv
// One-entry skid buffer holding a cache response while decode back-pressures.
// Flush wins over push; push wins over pop.
module biriscv_fetch_skid
  import biriscv_defs::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_entry_i,
  input  logic               pop_i,
  output logic               valid_o,
  output logic [ENTRY_W-1:0] entry_o
);

  logic               valid_q, valid_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;

  // Next occupancy and stored entry.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      entry_d = push_entry_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/biriscv_fetch_frontend.sv
// Dual-issue fetch stage: owns the fetch PC, issues 64-bit aligned cache reads,
// forwards responses to decode with zero added latency and parks one response
// in a skid buffer while decode stalls. Branches redirect immediately and any
// response belonging to the old path is dropped.
module biriscv_fetch_frontend
  import biriscv_defs::*;
#(
  parameter logic [31:0] BOOT_VECTOR = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic [1:0]  branch_priv_i,
  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,
  input  logic [63:0] icache_inst_i,
  input  logic        fetch_accept_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [1:0]  icache_priv_o,
  output logic [31:0] pc_f_o,
  output logic        pc_accept_o,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_pred_branch_o,
  output logic        fetch_fault_fetch_o,
  output logic        fetch_fault_page_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic [1:0]   priv_q, priv_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [1:0]   req_pred_q, req_pred_d;
  logic         drop_q, drop_d;

  logic         skid_valid;
  fetch_entry_t skid_entry;
  fetch_entry_t live_entry;
  fetch_entry_t out_entry;
  logic         resp_live;
  logic         skid_push;
  logic         skid_pop;

  // A new read may go out only when nothing is outstanding and the skid is
  // empty or being drained this cycle, so at most one response is uncommitted.
  assign icache_rd_o = ~rst_i & (state_q == ST_IDLE) & (~skid_valid | fetch_accept_i);
  assign pc_accept_o = icache_rd_o & icache_accept_i;
  assign icache_pc_o = {pc_f_q[31:3], 3'b000};
  assign icache_priv_o = priv_q;
  assign pc_f_o = pc_f_q;

  // A response is live only if it belongs to the current path.
  assign resp_live = icache_valid_i & (state_q == ST_WAIT) & ~drop_q & ~branch_request_i;

  // Shape the raw cache response into a decode entry.
  always_comb begin
    live_entry             = '0;
    live_entry.instr       = icache_inst_i;
    live_entry.pc          = req_pc_q;
    live_entry.pred        = req_pred_q;
    live_entry.fault_fetch = icache_error_i;
    live_entry.fault_page  = icache_page_fault_i;
    if (req_pc_q[2]) begin
      live_entry.instr[31:0] = NOP_INSTR;
    end
    if (icache_error_i | icache_page_fault_i) begin
      live_entry.instr = '0;
    end
  end

  // The parked entry is older than any live response, so it goes first.
  assign fetch_valid_o = ~rst_i & ~branch_request_i & (skid_valid | resp_live);
  assign out_entry = fetch_valid_o ? (skid_valid ? skid_entry : live_entry) : '0;

  assign fetch_instr_o       = out_entry.instr;
  assign fetch_pc_o          = out_entry.pc;
  assign fetch_pred_branch_o = out_entry.pred;
  assign fetch_fault_fetch_o = out_entry.fault_fetch;
  assign fetch_fault_page_o  = out_entry.fault_page;

  assign skid_push = resp_live & ~fetch_accept_i;
  assign skid_pop  = skid_valid & fetch_accept_i;

  biriscv_fetch_skid u_skid (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (branch_request_i),
    .push_i       (skid_push),
    .push_entry_i (live_entry),
    .pop_i        (skid_pop),
    .valid_o      (skid_valid),
    .entry_o      (skid_entry)
  );

  // Next-state: request tracking, PC advance, redirect and drop bookkeeping.
  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    priv_d     = priv_q;
    req_pc_d   = req_pc_q;
    req_pred_d = req_pred_q;
    drop_d     = drop_q;

    if (pc_accept_o) begin
      req_pc_d   = pc_f_q;
      req_pred_d = next_taken_f_i;
      pc_f_d     = next_pc_f_i;
      state_d    = ST_WAIT;
    end

    if ((state_q == ST_WAIT) && icache_valid_i) begin
      state_d = ST_IDLE;
      drop_d  = 1'b0;
    end

    // Redirect overrides the predictor; whatever is in flight (or just
    // accepted) belongs to the old path and must be swallowed.
    if (branch_request_i) begin
      pc_f_d = branch_pc_i;
      priv_d = branch_priv_i;
      drop_d = pc_accept_o | ((state_q == ST_WAIT) & ~icache_valid_i);
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pc_f_q     <= BOOT_VECTOR;
      priv_q     <= PRIV_MACHINE;
      req_pc_q   <= '0;
      req_pred_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      priv_q     <= priv_d;
      req_pc_q   <= req_pc_d;
      req_pred_q <= req_pred_d;
      drop_q     <= drop_d;
    end
  end

  // A response with nothing outstanding is a cache protocol violation.
  a_no_resp_when_idle: assert property (
    @(posedge clk_i) disable iff (rst_i) !(icache_valid_i && (state_q == ST_IDLE))
  );

endmodule

// File: tb/tb_biriscv_fetch_frontend.sv
// Randomised scoreboard bench for the fetch front end. The stimulus side plays
// the cache and predictor, tracks requests as whole transactions and pushes the
// pair decode should receive; a monitor compares at the falling edge.
module tb_biriscv_fetch_frontend;

  localparam logic [31:0] BOOT = 32'h80000000;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        branch_request_i = 1'b0;
  logic [31:0] branch_pc_i = '0;
  logic [1:0]  branch_priv_i = '0;
  logic [31:0] next_pc_f_i = '0;
  logic [1:0]  next_taken_f_i = '0;
  logic        icache_accept_i = 1'b0;
  logic        icache_valid_i = 1'b0;
  logic        icache_error_i = 1'b0;
  logic        icache_page_fault_i = 1'b0;
  logic [63:0] icache_inst_i = '0;
  logic        fetch_accept_i = 1'b0;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic [1:0]  icache_priv_o;
  logic [31:0] pc_f_o;
  logic        pc_accept_o;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_pred_branch_o;
  logic        fetch_fault_fetch_o;
  logic        fetch_fault_page_o;

  biriscv_fetch_frontend dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .branch_request_i    (branch_request_i),
    .branch_pc_i         (branch_pc_i),
    .branch_priv_i       (branch_priv_i),
    .next_pc_f_i         (next_pc_f_i),
    .next_taken_f_i      (next_taken_f_i),
    .icache_accept_i     (icache_accept_i),
    .icache_valid_i      (icache_valid_i),
    .icache_error_i      (icache_error_i),
    .icache_page_fault_i (icache_page_fault_i),
    .icache_inst_i       (icache_inst_i),
    .fetch_accept_i      (fetch_accept_i),
    .icache_rd_o         (icache_rd_o),
    .icache_pc_o         (icache_pc_o),
    .icache_priv_o       (icache_priv_o),
    .pc_f_o              (pc_f_o),
    .pc_accept_o         (pc_accept_o),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_instr_o       (fetch_instr_o),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_pred_branch_o (fetch_pred_branch_o),
    .fetch_fault_fetch_o (fetch_fault_fetch_o),
    .fetch_fault_page_o  (fetch_fault_page_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] instr;
    logic [31:0] pc;
    logic [1:0]  pred;
    logic        ff;
    logic        fp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  // Per-cycle expectations for the request side.
  logic        exp_rd, exp_acc;
  logic [31:0] exp_pc;
  logic [1:0]  exp_priv;

  // Reference model: fetch PC, privilege and the single outstanding request.
  logic [31:0] m_pc;
  logic [1:0]  m_priv;
  bit          out_busy;
  int          out_cnt;
  logic [31:0] r_pc;
  logic [1:0]  r_pred;
  bit          r_dropped;

  // Random stimulus scratch.
  bit          s_br, s_iacc, s_facc, s_err, s_pf;
  logic [31:0] s_bpc, s_npc;
  logic [1:0]  s_bpriv, s_ntk;
  logic [63:0] s_data;
  int          s_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] nx();
    return (m_pc & 32'hFFFF_FFF8) + 32'd8;
  endfunction

  // Monitor: request-side signals every cycle, delivered pairs against the scoreboard.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("icache_rd", {63'd0, icache_rd_o}, {63'd0, exp_rd});
      check("pc_accept", {63'd0, pc_accept_o}, {63'd0, exp_acc});
      check("pc_f", {32'd0, pc_f_o}, {32'd0, exp_pc});
      check("icache_pc", {32'd0, icache_pc_o}, {32'd0, exp_pc[31:3], 3'b000});
      check("icache_priv", {62'd0, icache_priv_o}, {62'd0, exp_priv});
      check("fetch_valid", {63'd0, fetch_valid_o}, {63'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        if (fetch_valid_o) begin
          check("fetch_instr", fetch_instr_o, exp_q[0].instr);
          check("fetch_pc", {32'd0, fetch_pc_o}, {32'd0, exp_q[0].pc});
          check("fetch_pred", {62'd0, fetch_pred_branch_o}, {62'd0, exp_q[0].pred});
          check("fault_fetch", {63'd0, fetch_fault_fetch_o}, {63'd0, exp_q[0].ff});
          check("fault_page", {63'd0, fetch_fault_page_o}, {63'd0, exp_q[0].fp});
        end
        if (fetch_accept_i) begin
          $display("deliver pc=%h instr=%h pred=%0d ff=%0d fp=%0d",
                   exp_q[0].pc, exp_q[0].instr, exp_q[0].pred, exp_q[0].ff, exp_q[0].fp);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; the model works out what this cycle must show.
  task automatic step(input bit br, input logic [31:0] bpc, input logic [1:0] bpriv,
                      input logic [31:0] npc, input logic [1:0] ntk,
                      input bit iacc, input bit facc, input logic [63:0] data,
                      input bit err, input bit pf, input int lat);
    bit   resp;
    exp_t e;
    @(posedge clk_i);
    #1;
    resp = out_busy && (out_cnt == 0);
    if (out_busy && !resp) out_cnt--;
    branch_request_i    = br;
    branch_pc_i         = bpc;
    branch_priv_i       = bpriv;
    next_pc_f_i         = npc;
    next_taken_f_i      = ntk;
    icache_accept_i     = iacc;
    fetch_accept_i      = facc;
    icache_valid_i      = resp;
    icache_inst_i       = data;
    icache_error_i      = resp & err;
    icache_page_fault_i = resp & pf;

    exp_pc   = m_pc;
    exp_priv = m_priv;
    exp_rd   = !out_busy && ((exp_q.size() == 0) || facc);
    exp_acc  = exp_rd && iacc;

    if (br) exp_q.delete();
    if (resp) begin
      out_busy = 1'b0;
      if (!r_dropped && !br) begin
        e.pc   = r_pc;
        e.pred = r_pred;
        e.ff   = err;
        e.fp   = pf;
        if (err || pf)    e.instr = 64'd0;
        else if (r_pc[2]) e.instr = {data[63:32], NOP};
        else              e.instr = data;
        exp_q.push_back(e);
      end
    end
    if (exp_acc) begin
      out_busy  = 1'b1;
      out_cnt   = lat - 1;
      r_pc      = m_pc;
      r_pred    = ntk;
      r_dropped = br;
      m_pc      = npc;
    end
    if (br) begin
      m_pc   = bpc;
      m_priv = bpriv;
      if (out_busy) r_dropped = 1'b1;
    end
    chk_en = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    chk_en = 1'b0;
    rst_i = 1'b1;
    branch_request_i = 1'b0;
    icache_accept_i = 1'b0;
    icache_valid_i = 1'b0;
    icache_error_i = 1'b0;
    icache_page_fault_i = 1'b0;
    fetch_accept_i = 1'b0;
    exp_q.delete();
    out_busy = 1'b0;
    m_pc = BOOT;
    m_priv = 2'b11;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_rd", {63'd0, icache_rd_o}, 64'd0);
    check("rst_accept", {63'd0, pc_accept_o}, 64'd0);
    check("rst_valid", {63'd0, fetch_valid_o}, 64'd0);
    check("rst_instr", fetch_instr_o, 64'd0);
    check("rst_fpc", {32'd0, fetch_pc_o}, 64'd0);
    check("rst_pc_f", {32'd0, pc_f_o}, {32'd0, BOOT});
    check("rst_priv", {62'd0, icache_priv_o}, 64'd3);
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();

    // Boot fetch, one-cycle response, delivered immediately.
    step(0, 0, 3, nx(), 2'b00, 1, 1, 64'h00100093_00000013, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 0, 1, 64'h00100093_00000013, 0, 0, 1);

    // Decode stalls for five cycles: the pair waits in the skid, no new reads.
    step(0, 0, 3, nx(), 2'b00, 1, 0, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 1, 0, 64'h11111111_22222222, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 3, nx(), 2'b00, 1, 0, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 1, 1, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 0, 1, 64'h33333333_44444444, 0, 0, 1);

    // Redirect while a request is outstanding; the old response is dropped.
    step(0, 0, 3, nx(), 2'b00, 1, 1, 64'h0, 0, 0, 3);
    step(1, 32'h80001004, 3, 0, 2'b00, 1, 1, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 1, 1, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 1, 1, 64'hDEADBEEF_DEADBEEF, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 1, 1, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 0, 1, 64'h55555555_66666666, 0, 0, 1);

    // Page fault response.
    step(0, 0, 3, nx(), 2'b00, 1, 1, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 0, 1, 64'h77777777_88888888, 0, 1, 1);

    // Predicted-taken slot 0 and predictor target.
    step(0, 0, 3, 32'h80000400, 2'b01, 1, 1, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 0, 1, 64'h99999999_AAAAAAAA, 0, 0, 1);

    // Branch coincides with a skid-held pair and a newly accepted request.
    step(0, 0, 3, nx(), 2'b00, 1, 0, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 1, 0, 64'hBBBBBBBB_CCCCCCCC, 0, 0, 1);
    step(1, 32'h80002000, 3, nx(), 2'b00, 1, 1, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 1, 1, 64'hEEEEEEEE_FFFFFFFF, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 1, 1, 64'h0, 0, 0, 1);
    step(0, 0, 3, nx(), 2'b00, 0, 1, 64'h12345678_9ABCDEF0, 0, 0, 1);

    // Randomised traffic, with one reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      s_br    = ($urandom_range(0, 11) == 0);
      s_bpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      s_bpriv = 2'($urandom_range(0, 3));
      s_npc   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : nx();
      s_ntk   = 2'($urandom_range(0, 3));
      s_iacc  = ($urandom_range(0, 9) < 7);
      s_facc  = ($urandom_range(0, 9) < 6);
      s_data  = {$urandom, $urandom};
      s_err   = ($urandom_range(0, 9) == 0);
      s_pf    = ($urandom_range(0, 9) == 0);
      s_lat   = $urandom_range(1, 3);
      step(s_br, s_bpc, s_bpriv, s_npc, s_ntk, s_iacc, s_facc, s_data, s_err, s_pf, s_lat);
    end

    @(posedge clk_i);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
